// File: rtl/mono_data_tx.sv
// Hit buffer and serial readout for the monolithic pixel chip.
// Hits are queued in a FIFO; each DAQ READ edge shifts one word out on DATA, MSB first.
module mono_data_tx #(
  parameter int DEPTH     = 16,
  parameter int WORD_BITS = 27
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 HIT_WRITE,
  input  logic [WORD_BITS-1:0] HIT_DATA,
  output logic                 HIT_FULL,
  input  logic                 nRST,
  input  logic                 FREEZE,
  input  logic                 READ,
  output logic                 TOKEN,
  output logic                 DATA,
  output logic                 BUSY,
  output logic [7:0]           LOST_CNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WORD_BITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nxt;

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt, pending, pending_nxt;
  logic [WORD_BITS-1:0] shreg;
  logic [BW-1:0]        bit_cnt;
  logic                 read_q, read_prev, freeze_q, token_nxt;
  logic                 push, pop, lost, rd_rise, avail;

  assign HIT_FULL = (count == CW'(DEPTH));
  assign pop      = (state == LOAD) && (count != '0);
  // A full buffer still accepts a hit when the same cycle frees a slot.
  assign push     = nRST && HIT_WRITE && (!HIT_FULL || pop);
  assign lost     = nRST && HIT_WRITE && HIT_FULL && !pop;
  assign rd_rise  = read_q && !read_prev;
  assign avail    = freeze_q ? (pending != '0) : (count != '0);
  assign BUSY     = (state == SHIFT);
  assign DATA     = (state == SHIFT) && shreg[WORD_BITS-1];

  always_comb begin
    count_nxt   = nRST ? (count + CW'(push) - CW'(pop)) : '0;
    pending_nxt = pending;
    if (!nRST)
      pending_nxt = '0;
    else if (FREEZE && !freeze_q)
      pending_nxt = count - CW'(pop);
    else if (freeze_q && pop && (pending != '0))
      pending_nxt = pending - 1'b1;
    token_nxt = FREEZE ? (pending_nxt != '0) : (count_nxt != '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_rise && avail) state_nxt = LOAD;
      LOAD:    state_nxt = pop ? SHIFT : IDLE;
      SHIFT:   if (bit_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!nRST) state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wr_ptr] <= HIT_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      TOKEN     <= 1'b0;
      freeze_q  <= 1'b0;
      read_q    <= 1'b0;
      read_prev <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      LOST_CNT  <= '0;
    end else begin
      count    <= count_nxt;
      pending  <= pending_nxt;
      TOKEN    <= token_nxt;
      freeze_q <= FREEZE;
      if (!nRST) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        read_q    <= 1'b0;
        read_prev <= 1'b0;
        shreg     <= '0;
      end else begin
        read_q    <= READ;
        read_prev <= read_q;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          shreg   <= mem[rd_ptr];
          bit_cnt <= BW'(WORD_BITS - 1);
        end else if (state == SHIFT) begin
          shreg   <= {shreg[WORD_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
        end
      end
      // Readout reset leaves the lost-hit history intact.
      if (lost && (LOST_CNT != 8'hFF)) LOST_CNT <= LOST_CNT + 8'd1;
    end
  end
endmodule

// File: tb/tb_mono_data_tx.sv
// Directed bench for mono_data_tx: reset, readout timing, overflow, freeze and abort.
module tb_mono_data_tx;
  logic        CLK = 1'b0;
  logic        RST, HIT_WRITE, nRST, FREEZE, READ;
  logic [26:0] HIT_DATA;
  logic        HIT_FULL, TOKEN, DATA, BUSY;
  logic [7:0]  LOST_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  mono_data_tx #(.DEPTH(16), .WORD_BITS(27)) dut (
    .CLK(CLK), .RST(RST), .HIT_WRITE(HIT_WRITE), .HIT_DATA(HIT_DATA),
    .HIT_FULL(HIT_FULL), .nRST(nRST), .FREEZE(FREEZE), .READ(READ),
    .TOKEN(TOKEN), .DATA(DATA), .BUSY(BUSY), .LOST_CNT(LOST_CNT)
  );

  always #12 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [26:0] d);
    HIT_WRITE = 1'b1;
    HIT_DATA  = d;
    tick();
    HIT_WRITE = 1'b0;
  endtask

  // One READ pulse; collects the shifted word and BUSY/DATA activity over edges n+1..n+29.
  task automatic read_word(input bit push_in_load, input logic [26:0] pdata,
                           output logic [26:0] w, output int busy_n, output int data_out_n,
                           output logic tok_sh, output logic full_sh);
    busy_n = 0; data_out_n = 0; w = '0;
    READ = 1'b1; tick(); READ = 1'b0; tick();
    busy_n += int'(BUSY); data_out_n += int'(DATA);
    if (push_in_load) begin HIT_WRITE = 1'b1; HIT_DATA = pdata; end
    tick();
    HIT_WRITE = 1'b0;
    tok_sh = TOKEN; full_sh = HIT_FULL;
    for (int k = 0; k < 27; k++) begin
      w = {w[25:0], DATA};
      busy_n += int'(BUSY);
      tick();
    end
    busy_n += int'(BUSY); data_out_n += int'(DATA);
  endtask

  task automatic test_reset();
    RST = 1'b1; tick();
    n_cmp++; if (TOKEN !== 1'b0)    begin n_bad++; $display("FAIL reset_token got=%b exp=0", TOKEN); end
    n_cmp++; if (DATA !== 1'b0)     begin n_bad++; $display("FAIL reset_data got=%b exp=0", DATA); end
    n_cmp++; if (BUSY !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_cmp++; if (HIT_FULL !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", HIT_FULL); end
    n_cmp++; if (LOST_CNT !== 8'd0) begin n_bad++; $display("FAIL reset_lost got=%0d exp=0", LOST_CNT); end
    RST = 1'b0; tick();
  endtask

  task automatic test_basic();
    logic [26:0] w; int b, d; logic t, f;
    push_word(27'h5A5A5A5);
    n_cmp++; if (TOKEN !== 1'b1) begin n_bad++; $display("FAIL basic_token_up got=%b exp=1", TOKEN); end
    read_word(1'b0, '0, w, b, d, t, f);
    n_cmp++; if (w !== 27'h5A5A5A5) begin n_bad++; $display("FAIL basic_word got=%h exp=5a5a5a5", w); end
    n_cmp++; if (b != 27) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=27", b); end
    n_cmp++; if (d != 0)  begin n_bad++; $display("FAIL basic_data_idle got=%0d exp=0", d); end
    n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL basic_token_down got=%b exp=0", t); end
  endtask

  task automatic test_overflow();
    logic [26:0] w; int b, d; logic t, f;
    for (int i = 0; i < 18; i++) begin
      push_word(27'h1000000 + 27'(i));
      if (i == 14) begin
        n_cmp++; if (HIT_FULL !== 1'b0) begin n_bad++; $display("FAIL ovf_full15 got=%b exp=0", HIT_FULL); end
      end
      if (i == 15) begin
        n_cmp++; if (HIT_FULL !== 1'b1) begin n_bad++; $display("FAIL ovf_full16 got=%b exp=1", HIT_FULL); end
      end
    end
    n_cmp++; if (LOST_CNT !== 8'd2) begin n_bad++; $display("FAIL ovf_lost got=%0d exp=2", LOST_CNT); end
    for (int i = 0; i < 16; i++) begin
      read_word(1'b0, '0, w, b, d, t, f);
      n_cmp++;
      if (w !== 27'h1000000 + 27'(i)) begin
        n_bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, w, 27'h1000000 + 27'(i));
      end
    end
    n_cmp++; if (TOKEN !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_token got=%b exp=0", TOKEN); end
  endtask

  task automatic test_full_pushpop();
    logic [26:0] w; int b, d; logic t, f;
    for (int i = 0; i < 16; i++) push_word(27'h2AA0000 + 27'(i));
    read_word(1'b1, 27'h7ABCDEF, w, b, d, t, f);
    n_cmp++; if (w !== 27'h2AA0000) begin n_bad++; $display("FAIL pp_first got=%h exp=2aa0000", w); end
    n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL pp_still_full got=%b exp=1", f); end
    n_cmp++; if (LOST_CNT !== 8'd2) begin n_bad++; $display("FAIL pp_lost got=%0d exp=2", LOST_CNT); end
    for (int i = 1; i < 16; i++) begin
      read_word(1'b0, '0, w, b, d, t, f);
      n_cmp++;
      if (w !== 27'h2AA0000 + 27'(i)) begin
        n_bad++; $display("FAIL pp_word%0d got=%h exp=%h", i, w, 27'h2AA0000 + 27'(i));
      end
    end
    read_word(1'b0, '0, w, b, d, t, f);
    n_cmp++; if (w !== 27'h7ABCDEF) begin n_bad++; $display("FAIL pp_pushed got=%h exp=7abcdef", w); end
    n_cmp++; if (TOKEN !== 1'b0) begin n_bad++; $display("FAIL pp_token got=%b exp=0", TOKEN); end
  endtask

  task automatic test_freeze();
    logic [26:0] w; int b, d; logic t, f;
    for (int i = 0; i < 3; i++) push_word(27'h0300000 + 27'(i));
    FREEZE = 1'b1; tick();
    push_word(27'h0400000); push_word(27'h0400001);
    n_cmp++; if (TOKEN !== 1'b1) begin n_bad++; $display("FAIL frz_token_up got=%b exp=1", TOKEN); end
    for (int i = 0; i < 3; i++) begin
      read_word(1'b0, '0, w, b, d, t, f);
      n_cmp++;
      if (w !== 27'h0300000 + 27'(i)) begin
        n_bad++; $display("FAIL frz_word%0d got=%h exp=%h", i, w, 27'h0300000 + 27'(i));
      end
    end
    n_cmp++; if (TOKEN !== 1'b0) begin n_bad++; $display("FAIL frz_token_down got=%b exp=0", TOKEN); end
    read_word(1'b0, '0, w, b, d, t, f);
    n_cmp++; if (b != 0) begin n_bad++; $display("FAIL frz_read_ignored busy=%0d exp=0", b); end
    FREEZE = 1'b0; tick();
    n_cmp++; if (TOKEN !== 1'b1) begin n_bad++; $display("FAIL frz_release_token got=%b exp=1", TOKEN); end
    for (int i = 0; i < 2; i++) begin
      read_word(1'b0, '0, w, b, d, t, f);
      n_cmp++;
      if (w !== 27'h0400000 + 27'(i)) begin
        n_bad++; $display("FAIL frz_late%0d got=%h exp=%h", i, w, 27'h0400000 + 27'(i));
      end
    end
  endtask

  task automatic test_abort();
    logic [26:0] w1;
    w1 = 27'h3C0F0F1;
    push_word(w1); push_word(27'h0000055);
    READ = 1'b1; tick(); READ = 1'b0; tick(); tick();
    repeat (16) tick();
    n_cmp++; if (DATA !== w1[10]) begin n_bad++; $display("FAIL abort_bit10 got=%b exp=%b", DATA, w1[10]); end
    nRST = 1'b0; HIT_WRITE = 1'b1; HIT_DATA = 27'h1111111; tick();
    n_cmp++; if (DATA !== 1'b0)  begin n_bad++; $display("FAIL abort_data got=%b exp=0", DATA); end
    n_cmp++; if (BUSY !== 1'b0)  begin n_bad++; $display("FAIL abort_busy got=%b exp=0", BUSY); end
    n_cmp++; if (TOKEN !== 1'b0) begin n_bad++; $display("FAIL abort_token got=%b exp=0", TOKEN); end
    n_cmp++; if (LOST_CNT !== 8'd2) begin n_bad++; $display("FAIL abort_lost got=%0d exp=2", LOST_CNT); end
    nRST = 1'b1; HIT_WRITE = 1'b0; tick();
    n_cmp++; if (TOKEN !== 1'b0) begin n_bad++; $display("FAIL abort_empty got=%b exp=0", TOKEN); end
  endtask

  task automatic test_ignored_reads();
    logic [26:0] w; int b, d; logic t, f;
    b = 0; d = 0;
    READ = 1'b1; tick(); READ = 1'b0;
    repeat (30) begin b += int'(BUSY); d += int'(DATA); tick(); end
    n_cmp++; if (b != 0 || d != 0) begin n_bad++; $display("FAIL empty_read busy=%0d data=%0d exp=0/0", b, d); end
    push_word(27'h6000001); push_word(27'h6000002);
    b = 0;
    READ = 1'b1; tick(); READ = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (j == 10) READ = 1'b1;
      if (j == 11) READ = 1'b0;
      b += int'(BUSY);
      tick();
    end
    n_cmp++; if (b != 27) begin n_bad++; $display("FAIL b2b_busy got=%0d exp=27", b); end
    n_cmp++; if (TOKEN !== 1'b1) begin n_bad++; $display("FAIL b2b_token got=%b exp=1", TOKEN); end
    read_word(1'b0, '0, w, b, d, t, f);
    n_cmp++; if (w !== 27'h6000002) begin n_bad++; $display("FAIL b2b_second got=%h exp=6000002", w); end
  endtask

  initial begin
    RST = 1'b1; nRST = 1'b1; HIT_WRITE = 1'b0; HIT_DATA = '0; FREEZE = 1'b0; READ = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_freeze();
    test_abort();
    test_ignored_reads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
